// File: rtl/speed_timer_pkg.sv
// Shared types and default constants for the speed timer and its period lookup.
package speed_timer_pkg;

    localparam int unsigned DEF_CNT_W      = 7;
    localparam int unsigned DEF_NUM_SPEEDS = 4;
    localparam int unsigned DEF_SEL_W      = 2;
    localparam int unsigned DEF_PERIOD_0   = 10;
    localparam int unsigned DEF_PERIOD_1   = 7;
    localparam int unsigned DEF_PERIOD_2   = 4;
    localparam int unsigned DEF_PERIOD_3   = 2;
    localparam int unsigned TOCNT_W        = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/speed_period_lut.sv
// Combinational speed -> period map; zero periods become 1 and unknown speeds use PERIOD_0.
module speed_period_lut import speed_timer_pkg::*; #(
    parameter int unsigned CNT_W      = DEF_CNT_W,
    parameter int unsigned NUM_SPEEDS = DEF_NUM_SPEEDS,
    parameter int unsigned SEL_W      = DEF_SEL_W,
    parameter int unsigned PERIOD_0   = DEF_PERIOD_0,
    parameter int unsigned PERIOD_1   = DEF_PERIOD_1,
    parameter int unsigned PERIOD_2   = DEF_PERIOD_2,
    parameter int unsigned PERIOD_3   = DEF_PERIOD_3
) (
    input  logic [SEL_W-1:0] speed_i,
    output logic [CNT_W-1:0] period_c_o
);

    localparam logic [CNT_W-1:0] P0_RAW = CNT_W'(PERIOD_0);
    localparam logic [CNT_W-1:0] P1_RAW = CNT_W'(PERIOD_1);
    localparam logic [CNT_W-1:0] P2_RAW = CNT_W'(PERIOD_2);
    localparam logic [CNT_W-1:0] P3_RAW = CNT_W'(PERIOD_3);

    // A zero-length period would never reach its terminal count, so it runs as 1.
    localparam logic [CNT_W-1:0] P0 = (P0_RAW == '0) ? CNT_W'(1) : P0_RAW;
    localparam logic [CNT_W-1:0] P1 = (P1_RAW == '0) ? CNT_W'(1) : P1_RAW;
    localparam logic [CNT_W-1:0] P2 = (P2_RAW == '0) ? CNT_W'(1) : P2_RAW;
    localparam logic [CNT_W-1:0] P3 = (P3_RAW == '0) ? CNT_W'(1) : P3_RAW;

    logic [31:0] sel_wide;

    always_comb begin
        sel_wide   = 32'(speed_i);
        period_c_o = P0;
        if (sel_wide < NUM_SPEEDS) begin
            case (sel_wide)
                32'd1:   period_c_o = P1;
                32'd2:   period_c_o = P2;
                32'd3:   period_c_o = P3;
                default: period_c_o = P0;
            endcase
        end
    end

endmodule

// File: rtl/speed_timer.sv
// Tick-driven interval timer with pause, restart, one-shot and boundary-latched speed.
// Optional SPEED_TIMER_TOCNT_EN adds a saturating timeout counter output (to_count).
module speed_timer import speed_timer_pkg::*; #(
    parameter int unsigned CNT_W      = DEF_CNT_W,
    parameter int unsigned NUM_SPEEDS = DEF_NUM_SPEEDS,
    parameter int unsigned SEL_W      = DEF_SEL_W,
    parameter int unsigned PERIOD_0   = DEF_PERIOD_0,
    parameter int unsigned PERIOD_1   = DEF_PERIOD_1,
    parameter int unsigned PERIOD_2   = DEF_PERIOD_2,
    parameter int unsigned PERIOD_3   = DEF_PERIOD_3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             tick,
    input  logic [SEL_W-1:0] speed,
    input  logic             oneshot,
    input  logic             restart,
    output logic             timeout,
    output logic [CNT_W-1:0] count,
    output logic             running,
    output logic             done
`ifdef SPEED_TIMER_TOCNT_EN
   ,output logic [TOCNT_W-1:0] to_count
`endif
);

    localparam logic [CNT_W-1:0] P0_RAW     = CNT_W'(PERIOD_0);
    localparam logic [CNT_W-1:0] PERIOD_RST = (P0_RAW == '0) ? CNT_W'(1) : P0_RAW;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             oneshot_q, oneshot_d;
    logic             timeout_q, timeout_d;
    logic             running_q, done_q;
    logic             restart_hit;
    logic [CNT_W-1:0] lut_period;

    speed_period_lut #(
        .CNT_W      (CNT_W),
        .NUM_SPEEDS (NUM_SPEEDS),
        .SEL_W      (SEL_W),
        .PERIOD_0   (PERIOD_0),
        .PERIOD_1   (PERIOD_1),
        .PERIOD_2   (PERIOD_2),
        .PERIOD_3   (PERIOD_3)
    ) u_lut (
        .speed_i    (speed),
        .period_c_o (lut_period)
    );

    // Next-state: restart outranks everything except IDLE, where it is ignored.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        period_d    = period_q;
        oneshot_d   = oneshot_q;
        timeout_d   = 1'b0;
        restart_hit = restart && (state_q != ST_IDLE);

        if (restart_hit) begin
            count_d  = '0;
            period_d = lut_period;
            state_d  = enable ? ST_RUN : ST_PAUSE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (enable) begin
                        state_d   = ST_RUN;
                        count_d   = '0;
                        period_d  = lut_period;
                        oneshot_d = oneshot;
                    end
                end
                ST_RUN: begin
                    if (!enable) begin
                        state_d = ST_PAUSE;
                    end else if (tick) begin
                        if (count_q == period_q - CNT_W'(1)) begin
                            count_d   = '0;
                            timeout_d = 1'b1;
                            period_d  = lut_period;
                            if (oneshot_q) begin
                                state_d = ST_DONE;
                            end
                        end else begin
                            count_d = count_q + CNT_W'(1);
                        end
                    end
                end
                ST_PAUSE: begin
                    if (enable) begin
                        state_d = ST_RUN;
                    end
                end
                ST_DONE: begin
                    count_d = '0;
                    if (!enable) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    count_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            period_q  <= PERIOD_RST;
            oneshot_q <= 1'b0;
            timeout_q <= 1'b0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            period_q  <= period_d;
            oneshot_q <= oneshot_d;
            timeout_q <= timeout_d;
            running_q <= (state_d == ST_RUN);
            done_q    <= (state_d == ST_DONE);
        end
    end

    assign timeout = timeout_q;
    assign count   = count_q;
    assign running = running_q;
    assign done    = done_q;

`ifdef SPEED_TIMER_TOCNT_EN
    logic [TOCNT_W-1:0] to_cnt_q;

    // Timeouts since reset or an effective restart, sticking at all-ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt_q <= '0;
        end else if (restart_hit) begin
            to_cnt_q <= '0;
        end else if (timeout_d && (to_cnt_q != {TOCNT_W{1'b1}})) begin
            to_cnt_q <= to_cnt_q + TOCNT_W'(1);
        end
    end

    assign to_count = to_cnt_q;
`endif

endmodule
